// File: rtl/sobel_edge_detect.sv
// sobel_edge_detect
// 3x3 Sobel gradient magnitude and thresholded edge map for a grey-level
// pixel stream with valid/hs/vs sideband. Output is four clocks behind the
// input sample; the sideband is delayed by the same four registers.
//
// Ports:
//   clk            pixel clock
//   reset_p        asynchronous active-high reset (line memories not cleared)
//   data_in        filtered pixel
//   data_in_valid  pixel qualifier
//   data_in_hs     high during active line
//   data_in_vs     high during active frame
//   threshold      edge threshold (DATA_WIDTH+3 bits), quasi-static
//   mag_out        gradient magnitude, saturated to DATA_WIDTH bits
//   data_out       all-ones where magnitude exceeds threshold, else 0
//   data_out_valid / data_out_hs / data_out_vs  sideband delayed by 4
module sobel_edge_detect #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int COL_BITS   = 10
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    input  logic                  data_in_hs,
    input  logic                  data_in_vs,
    input  logic [DATA_WIDTH+2:0] threshold,
    output logic [DATA_WIDTH-1:0] mag_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  data_out_hs,
    output logic                  data_out_vs
);

    localparam int SW = DATA_WIDTH + 2;
    localparam int MW = DATA_WIDTH + 3;
    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_WIDTH - 1);

    // p0 + 2*p1 + p2 over one window edge; cannot overflow SW bits
    function automatic logic [SW-1:0] edge_sum(input logic [DATA_WIDTH-1:0] a,
                                               input logic [DATA_WIDTH-1:0] b,
                                               input logic [DATA_WIDTH-1:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [SW-1:0] abs_diff(input logic [SW-1:0] a,
                                               input logic [SW-1:0] b);
        logic signed [SW:0] d;
        logic signed [SW:0] m;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        m = d[SW] ? -d : d;
        return m[SW-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat_mag(input logic [MW-1:0] m);
        return (|m[MW-1:DATA_WIDTH]) ? '1 : m[DATA_WIDTH-1:0];
    endfunction

    logic                  active;
    logic                  pix;
    logic [COL_BITS-1:0]   col_cnt;
    logic [1:0]            row_cnt;
    logic                  hs_prev;
    logic [DATA_WIDTH-1:0] mem0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] mem1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] rd0, rd1, tap0, tap1;

    assign active = data_in_hs & data_in_vs;
    assign pix    = active & data_in_valid;
    assign rd0    = mem0[col_cnt];
    assign rd1    = mem1[col_cnt];
    // Lines not yet written in this frame read as zero, hiding stale contents
    assign tap1   = (row_cnt != 2'd0) ? rd1 : '0;
    assign tap0   = (row_cnt == 2'd2) ? rd0 : '0;

    always_ff @(posedge clk) begin
        if (pix) begin
            mem1[col_cnt] <= data_in;
            mem0[col_cnt] <= rd1;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            col_cnt <= '0;
            row_cnt <= '0;
            hs_prev <= 1'b0;
        end else begin
            hs_prev <= data_in_hs;
            if (!data_in_hs)
                col_cnt <= '0;
            else if (pix)
                col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + 1'b1;
            if (!data_in_vs)
                row_cnt <= '0;
            else if (hs_prev && !data_in_hs && row_cnt != 2'd2)
                row_cnt <= row_cnt + 1'b1;
        end
    end

    // Stage 1: window register (row 0 oldest line, column 2 newest pixel)
    logic [DATA_WIDTH-1:0] win_p1 [3][3];

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_p1[r][c] <= '0;
        end else if (!active) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_p1[r][c] <= '0;
        end else if (data_in_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_p1[r][0] <= win_p1[r][1];
                win_p1[r][1] <= win_p1[r][2];
            end
            win_p1[0][2] <= tap0;
            win_p1[1][2] <= tap1;
            win_p1[2][2] <= data_in;
        end
    end

    logic [SW-1:0]         sum_l_p2, sum_r_p2, sum_t_p2, sum_b_p2;
    logic [SW-1:0]         gx_p3, gy_p3;
    logic [MW-1:0]         mag;
    logic                  vld_p1, vld_p2, vld_p3, vld_p4;
    logic                  hs_p1, hs_p2, hs_p3, hs_p4;
    logic                  vs_p1, vs_p2, vs_p3, vs_p4;

    assign mag = {1'b0, gx_p3} + {1'b0, gy_p3};

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sum_l_p2 <= '0;
            sum_r_p2 <= '0;
            sum_t_p2 <= '0;
            sum_b_p2 <= '0;
            gx_p3    <= '0;
            gy_p3    <= '0;
            mag_out  <= '0;
            data_out <= '0;
        end else begin
            // Stage 2: column and row edge sums
            sum_l_p2 <= edge_sum(win_p1[0][0], win_p1[1][0], win_p1[2][0]);
            sum_r_p2 <= edge_sum(win_p1[0][2], win_p1[1][2], win_p1[2][2]);
            sum_t_p2 <= edge_sum(win_p1[0][0], win_p1[0][1], win_p1[0][2]);
            sum_b_p2 <= edge_sum(win_p1[2][0], win_p1[2][1], win_p1[2][2]);
            // Stage 3: absolute gradients
            gx_p3    <= abs_diff(sum_r_p2, sum_l_p2);
            gy_p3    <= abs_diff(sum_b_p2, sum_t_p2);
            // Stage 4: magnitude, saturation and threshold compare
            mag_out  <= sat_mag(mag);
            data_out <= (mag > threshold) ? '1 : '0;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            {vld_p1, vld_p2, vld_p3, vld_p4} <= '0;
            {hs_p1, hs_p2, hs_p3, hs_p4}     <= '0;
            {vs_p1, vs_p2, vs_p3, vs_p4}     <= '0;
        end else begin
            {vld_p1, vld_p2, vld_p3, vld_p4} <= {data_in_valid, vld_p1, vld_p2, vld_p3};
            {hs_p1, hs_p2, hs_p3, hs_p4}     <= {data_in_hs, hs_p1, hs_p2, hs_p3};
            {vs_p1, vs_p2, vs_p3, vs_p4}     <= {data_in_vs, vs_p1, vs_p2, vs_p3};
        end
    end

    assign data_out_valid = vld_p4;
    assign data_out_hs    = hs_p4;
    assign data_out_vs    = vs_p4;

endmodule
